// File: rtl/iic_slave_mem.sv
// iic_slave_mem: I2C target with an internal byte memory, addressed like a serial EEPROM
// with a single-byte word address. Supports byte/sequential write, current-address read
// and random read. Define IIC_SLAVE_WP_EN to add a write-protect input `wp`.
module iic_slave_mem #(
  parameter logic [6:0]  DEV_ADDR = 7'h50,
  parameter int unsigned ADDR_W   = 8  // at most 8: the word address is one bus byte
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              iic_clk,
  inout  wire               iic_sda,
`ifdef IIC_SLAVE_WP_EN
  input  logic              wp,
`endif
  output logic              busy,
  output logic              wr_strobe,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data
);

  typedef enum logic [3:0] {
    StIdle, StDevAddr, StDevAck, StWordAddr, StWordAck, StWrData, StWrAck, StRdData, StRdAck
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        scl_sync_q, sda_sync_q;
  logic              scl_prev_q, sda_prev_q;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [7:0]        shift_q, shift_d;
  logic              rw_q, rw_d;
  logic              ack_rise_q, ack_rise_d;  // the ACK bit's SCL rising edge has passed
  logic [ADDR_W-1:0] ptr_q, ptr_d, ptr_inc;
  logic              sda_low_q, sda_low_d;
  logic              wr_strobe_q, wr_strobe_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic              mem_we, wr_en;
  logic              scl_s, sda_s, scl_rise, scl_fall, bus_start, bus_stop;
  logic [7:0]        byte_in;
  logic [7:0]        mem [2**ADDR_W];

`ifdef IIC_SLAVE_WP_EN
  logic [1:0] wp_sync_q;

  // Synchronize the write-protect level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) wp_sync_q <= '0;
    else     wp_sync_q <= {wp_sync_q[0], wp};
  end

  assign wr_en = ~wp_sync_q[1];
`else
  assign wr_en = 1'b1;
`endif

  // Two-flop synchronizers plus one delay stage for edge detection. Cleared to 0 so that
  // leaving reset can never fabricate a START or STOP (both need SCL seen high twice).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_sync_q <= '0;
      sda_sync_q <= '0;
      scl_prev_q <= 1'b0;
      sda_prev_q <= 1'b0;
    end else begin
      scl_sync_q <= {scl_sync_q[0], iic_clk};
      sda_sync_q <= {sda_sync_q[0], iic_sda};
      scl_prev_q <= scl_sync_q[1];
      sda_prev_q <= sda_sync_q[1];
    end
  end

  assign scl_s     = scl_sync_q[1];
  assign sda_s     = sda_sync_q[1];
  assign scl_rise  = scl_s & ~scl_prev_q;
  assign scl_fall  = ~scl_s & scl_prev_q;
  assign bus_start = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
  assign bus_stop  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;
  assign byte_in   = {shift_q[6:0], sda_s};
  assign ptr_inc   = ptr_q + ADDR_W'(1);

  // Next-state logic: START/STOP first, then bit sampling on SCL rise, driving on SCL fall.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    rw_d        = rw_q;
    ack_rise_d  = ack_rise_q;
    ptr_d       = ptr_q;
    sda_low_d   = sda_low_q;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    mem_we      = 1'b0;

    if (bus_start) begin
      state_d    = StDevAddr;
      bit_cnt_d  = '0;
      ack_rise_d = 1'b0;
      sda_low_d  = 1'b0;
    end else if (bus_stop) begin
      state_d   = StIdle;
      sda_low_d = 1'b0;
    end else if (scl_rise) begin
      case (state_q)
        StDevAddr, StWordAddr, StWrData: begin
          shift_d   = byte_in;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            ack_rise_d = 1'b0;
            case (state_q)
              StDevAddr: begin
                if (byte_in[7:1] == DEV_ADDR) begin
                  state_d = StDevAck;
                  rw_d    = byte_in[0];
                end else begin
                  state_d   = StIdle;
                  sda_low_d = 1'b0;
                end
              end
              StWordAddr: begin
                ptr_d   = byte_in[ADDR_W-1:0];
                state_d = StWordAck;
              end
              default: begin
                state_d = StWrAck;
                if (wr_en) begin
                  mem_we      = 1'b1;
                  wr_strobe_d = 1'b1;
                  wr_addr_d   = ptr_q;
                  wr_data_d   = byte_in;
                end
              end
            endcase
          end
        end
        StDevAck, StWordAck, StWrAck: begin
          ack_rise_d = 1'b1;
          if (state_q == StDevAck && rw_q) shift_d = mem[ptr_q];
        end
        StRdData: begin
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d    = StRdAck;
            ack_rise_d = 1'b0;
          end
        end
        StRdAck: begin
          // The pointer advances past the byte just read on NACK as well, so a following
          // current-address read continues the sequence like an EEPROM.
          ptr_d = ptr_inc;
          if (sda_s) begin
            state_d = StIdle;
          end else begin
            shift_d    = mem[ptr_inc];
            ack_rise_d = 1'b1;
          end
        end
        default: ;
      endcase
    end else if (scl_fall) begin
      case (state_q)
        StDevAck, StWordAck, StWrAck: begin
          if (!ack_rise_q) begin
            sda_low_d = 1'b1;
          end else begin
            bit_cnt_d = '0;
            sda_low_d = 1'b0;
            case (state_q)
              StDevAck: begin
                if (rw_q) begin
                  state_d   = StRdData;
                  sda_low_d = ~shift_q[7];
                  shift_d   = {shift_q[6:0], 1'b1};
                end else begin
                  state_d = StWordAddr;
                end
              end
              StWordAck: state_d = StWrData;
              default: begin
                ptr_d   = ptr_inc;
                state_d = StWrData;
              end
            endcase
          end
        end
        StRdData: begin
          sda_low_d = ~shift_q[7];
          shift_d   = {shift_q[6:0], 1'b1};
        end
        StRdAck: begin
          if (!ack_rise_q) begin
            sda_low_d = 1'b0;
          end else begin
            state_d   = StRdData;
            bit_cnt_d = '0;
            sda_low_d = ~shift_q[7];
            shift_d   = {shift_q[6:0], 1'b1};
          end
        end
        default: ;
      endcase
    end
  end

  // Protocol state and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      rw_q        <= 1'b0;
      ack_rise_q  <= 1'b0;
      ptr_q       <= '0;
      sda_low_q   <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      rw_q        <= rw_d;
      ack_rise_q  <= ack_rise_d;
      ptr_q       <= ptr_d;
      sda_low_q   <= sda_low_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
    end
  end

  // Memory write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[ptr_q] <= byte_in;
  end

  assign iic_sda   = sda_low_q ? 1'b0 : 1'bz;
  assign busy      = (state_q != StIdle) && (state_q != StDevAddr);
  assign wr_strobe = wr_strobe_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;

endmodule

// File: tb/tb_iic_slave_mem.sv
// Bench for iic_slave_mem: a bit-banged bus master, an array/pointer model of the
// EEPROM, and a strobe monitor that checks every stored byte against the model.
module tb_iic_slave_mem;
  typedef logic [7:0] bq_t[$];

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic scl = 1'b1;
  logic m_low = 1'b0;
  wire  iic_sda;
  logic busy, wr_strobe;
  logic [7:0] wr_addr, wr_data;
`ifdef IIC_SLAVE_WP_EN
  logic wp = 1'b0;
`endif

  assign iic_sda = m_low ? 1'b0 : 1'bz;
  pullup (iic_sda);

  always #10 clk = ~clk;

  iic_slave_mem #(.DEV_ADDR(7'h50), .ADDR_W(8)) dut (
    .clk(clk),
    .rst(rst),
    .iic_clk(scl),
    .iic_sda(iic_sda),
`ifdef IIC_SLAVE_WP_EN
    .wp(wp),
`endif
    .busy(busy),
    .wr_strobe(wr_strobe),
    .wr_addr(wr_addr),
    .wr_data(wr_data)
  );

  int tests = 0;
  int fails = 0;

  // Behavioural model
  logic [7:0]  mem_m [256];
  bit          mem_v [256];
  logic [7:0]  ptr_m = 8'h00;
  bit          wp_m = 1'b0;
  logic [15:0] exp_q[$];
  bit          strobe_prev = 1'b0;
  logic [7:0]  seen_addr = 8'h00, seen_data = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Strobe monitor: each pulse must match the next modelled store and last one clk.
  always @(negedge clk) begin
    logic [15:0] e;
    if (!rst && wr_strobe) begin
      seen_addr = wr_addr;
      seen_data = wr_data;
      check("strobe_width", {31'b0, strobe_prev}, 0);
      if (exp_q.size() == 0) begin
        check("strobe_unexpected", {16'b0, wr_addr, wr_data}, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("strobe_addr_data", {16'b0, wr_addr, wr_data}, {16'b0, e});
      end
    end
    strobe_prev = !rst && wr_strobe;
  end

  function automatic bit bus_sda();
    return (iic_sda !== 1'b0);
  endfunction

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One SCL period; entered and left with SCL low. Samples SDA mid-high.
  task automatic clk_bit(input bit val, output bit seen);
    wait_clk(3); m_low = ~val;
    wait_clk(7); scl = 1'b1;
    wait_clk(5); seen = bus_sda();
    wait_clk(5); scl = 1'b0;
  endtask

  task automatic bus_start();
    wait_clk(3); m_low = 1'b0;
    wait_clk(7); scl = 1'b1;
    wait_clk(10); m_low = 1'b1;
    wait_clk(10); scl = 1'b0;
  endtask

  task automatic bus_stop();
    wait_clk(3); m_low = 1'b1;
    wait_clk(7); scl = 1'b1;
    wait_clk(10); m_low = 1'b0;
    wait_clk(10);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit exp_ack, input string name);
    bit s;
    for (int i = 7; i >= 0; i--) clk_bit(b[i], s);
    clk_bit(1'b1, s);
    check(name, {31'b0, !s}, {31'b0, exp_ack});
  endtask

  task automatic read_byte(output logic [7:0] b, input bit master_ack);
    bit s;
    for (int i = 7; i >= 0; i--) begin
      clk_bit(1'b1, s);
      b[i] = s;
    end
    clk_bit(!master_ack, s);
  endtask

  task automatic do_write(input logic [7:0] addr, input bq_t data);
    bus_start();
    send_byte(8'hA0, 1'b1, "wr_dev_ack");
    check("wr_busy", {31'b0, busy}, 1);
    send_byte(addr, 1'b1, "wr_word_ack");
    ptr_m = addr;
    foreach (data[i]) begin
      if (!wp_m) begin
        mem_m[ptr_m] = data[i];
        mem_v[ptr_m] = 1'b1;
        exp_q.push_back({ptr_m, data[i]});
      end
      send_byte(data[i], 1'b1, "wr_data_ack");
      ptr_m++;
    end
    bus_stop();
    check("wr_stop_busy", {31'b0, busy}, 0);
    check("strobe_missing", exp_q.size(), 0);
  endtask

  // rnd=1: random read from addr; rnd=0: current-address read. Last byte is NACKed.
  task automatic do_read(input bit rnd, input logic [7:0] addr, input int n, output bq_t got);
    logic [7:0] b;
    got = {};
    bus_start();
    if (rnd) begin
      send_byte(8'hA0, 1'b1, "rr_dev_ack");
      send_byte(addr, 1'b1, "rr_word_ack");
      ptr_m = addr;
      bus_start();
    end
    send_byte(8'hA1, 1'b1, "rd_dev_ack");
    for (int i = 0; i < n; i++) begin
      read_byte(b, i != n - 1);
      if (mem_v[ptr_m]) check("rd_data", {24'b0, b}, {24'b0, mem_m[ptr_m]});
      got.push_back(b);
      ptr_m++;
    end
    wait_clk(5);
    check("nack_sda_released", {31'b0, bus_sda()}, 1);
    check("nack_busy", {31'b0, busy}, 0);
    bus_stop();
  endtask

  initial begin
    bq_t d, got;
    bit s;
    int op, n;
    logic [7:0] a;

    wait_clk(5);
    rst = 1'b0;
    wait_clk(5);
    check("rst_busy", {31'b0, busy}, 0);
    check("rst_wr_strobe", {31'b0, wr_strobe}, 0);
    check("rst_wr_addr", {24'b0, wr_addr}, 0);
    check("rst_wr_data", {24'b0, wr_data}, 0);
    check("rst_sda", {31'b0, bus_sda()}, 1);

    // Byte write then random read
    d = {8'h5A}; do_write(8'h0D, d);
    d = {8'hD1}; do_write(8'h0A, d);
    check("lit_strobe_addr", {24'b0, seen_addr}, 32'h0A);
    check("lit_strobe_data", {24'b0, seen_data}, 32'hD1);
    do_read(1'b1, 8'h0A, 1, got);
    check("lit_rd_d1", {24'b0, got[0]}, 32'hD1);

    // Sequential write and read, then current-address read
    d = {8'hD1, 8'hD2, 8'hD3}; do_write(8'h0A, d);
    do_read(1'b1, 8'h0A, 3, got);
    check("lit_seq0", {24'b0, got[0]}, 32'hD1);
    check("lit_seq1", {24'b0, got[1]}, 32'hD2);
    check("lit_seq2", {24'b0, got[2]}, 32'hD3);
    do_read(1'b0, 8'h00, 1, got);
    check("lit_cur_0d", {24'b0, got[0]}, 32'h5A);

    // Address mismatch
    bus_start();
    send_byte(8'hA2, 1'b0, "mismatch_nack");
    check("mismatch_busy", {31'b0, busy}, 0);
    bus_stop();
    check("mismatch_no_strobe", exp_q.size(), 0);
    d = {8'h77}; do_write(8'h20, d);

    // Pointer wrap
    d = {8'h11, 8'h22}; do_write(8'hFF, d);
    do_read(1'b1, 8'hFF, 2, got);
    check("lit_wrap0", {24'b0, got[0]}, 32'h11);
    check("lit_wrap1", {24'b0, got[1]}, 32'h22);

    // Reset after four data bits of a write
    bus_start();
    send_byte(8'hA0, 1'b1, "rst_dev_ack");
    send_byte(8'h0A, 1'b1, "rst_word_ack");
    for (int i = 7; i >= 4; i--) clk_bit(i[0], s);
    m_low = 1'b0;
    wait_clk(2); rst = 1'b1;
    wait_clk(2); rst = 1'b0;
    ptr_m = 8'h00;
    wait_clk(2);
    check("rst_mid_sda", {31'b0, bus_sda()}, 1);
    check("rst_mid_busy", {31'b0, busy}, 0);
    for (int i = 3; i >= 0; i--) clk_bit(i[0], s);
    clk_bit(1'b1, s);
    check("rst_mid_no_ack", {31'b0, s}, 1);
    bus_stop();
    check("rst_mid_no_strobe", exp_q.size(), 0);
    do_read(1'b0, 8'h00, 1, got);
    check("lit_rst_ptr0", {24'b0, got[0]}, 32'h22);
    do_read(1'b1, 8'h0A, 1, got);
    check("lit_rst_mem_kept", {24'b0, got[0]}, 32'hD1);
    d = {8'h3C}; do_write(8'h0A, d);
    do_read(1'b1, 8'h0A, 1, got);
    check("lit_rst_rewrite", {24'b0, got[0]}, 32'h3C);

`ifdef IIC_SLAVE_WP_EN
    // Write protect
    d = {8'h99}; do_write(8'h0F, d);
    wp = 1'b1; wp_m = 1'b1; wait_clk(5);
    d = {8'h55}; do_write(8'h0F, d);
    wp = 1'b0; wp_m = 1'b0; wait_clk(5);
    do_read(1'b1, 8'h0F, 1, got);
    check("lit_wp_kept", {24'b0, got[0]}, 32'h99);
    d = {8'h55}; do_write(8'h0F, d);
    do_read(1'b1, 8'h0F, 1, got);
    check("lit_wp_off", {24'b0, got[0]}, 32'h55);
`endif

    // Randomized traffic against the model
    for (int it = 0; it < 20; it++) begin
      op = $urandom_range(0, 2);
      a  = 8'($urandom_range(0, 31));
      n  = $urandom_range(1, 4);
      if (op == 0) begin
        d = {};
        for (int k = 0; k < n; k++) d.push_back(8'($urandom));
        do_write(a, d);
      end else begin
        do_read(op == 1, a, n, got);
      end
    end

    wait_clk(10);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
